// File: rtl/delay_line_pkg.sv
// Shared defaults and types for the delay_line block.
package delay_line_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 4;
   localparam int unsigned CNT_W_DEF  = 4;

   // Occupancy of the delay line
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   // One stored entry at default widths: data word plus its remaining delay
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [CNT_W_DEF-1:0]  cnt;
   } entry_t;

endpackage

// File: rtl/delay_line_ctrl.sv
// Occupancy FSM, head/tail pointers and word count for delay_line.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_valid, i_take     upstream offer / downstream consume request
//   i_ready             registered head-ready from the storage side
//   i_flush             synchronous discard of all words
//   o_next              registered "can accept" flag
//   o_count, o_tail     registered occupancy and tail pointer
//   o_head_nxt_c        head pointer value after this edge
//   o_count_nxt_c       occupancy after this edge
//   o_accept_c          a word is written into the tail entry this edge
module delay_line_ctrl
   import delay_line_pkg::*;
#(
   parameter  int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned OCC_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic             i_take,
   input  logic             i_ready,
   input  logic             i_flush,
   output logic             o_next,
   output logic [OCC_W-1:0] o_count,
   output logic [PTR_W-1:0] o_tail,
   output logic [PTR_W-1:0] o_head_nxt_c,
   output logic [OCC_W-1:0] o_count_nxt_c,
   output logic             o_accept_c
);

   occ_e             r_state, w_state_nxt;
   logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
   logic [OCC_W-1:0] r_count, w_count_nxt;
   logic             r_next;
   logic             w_accept, w_take;

   // State, pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= OCC_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_next  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         r_next  <= (w_state_nxt != OCC_FULL);
      end
   end

   // Next state: flush wins over accept and take
   always_comb begin
      w_accept    = 1'b0;
      w_take      = 1'b0;
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_count_nxt = r_count;
      if (i_flush) begin
         w_state_nxt = OCC_EMPTY;
         w_head_nxt  = '0;
         w_tail_nxt  = '0;
         w_count_nxt = '0;
      end else begin
         // accept uses registered occupancy only, so a same-cycle take never frees a full slot
         w_accept = i_valid && r_next;
         w_take   = i_take && i_ready && (r_state != OCC_EMPTY);
         if (w_accept) w_tail_nxt = r_tail + PTR_W'(1);
         if (w_take)   w_head_nxt = r_head + PTR_W'(1);
         if (w_accept && !w_take)      w_count_nxt = r_count + OCC_W'(1);
         else if (w_take && !w_accept) w_count_nxt = r_count - OCC_W'(1);
         case (r_state)
            OCC_EMPTY: begin
               if (w_accept) w_state_nxt = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
               if (w_accept && !w_take && (r_count == OCC_W'(DEPTH - 1)))
                  w_state_nxt = OCC_FULL;
               else if (w_take && !w_accept && (r_count == OCC_W'(1)))
                  w_state_nxt = OCC_EMPTY;
            end
            OCC_FULL: begin
               if (w_take) w_state_nxt = OCC_PARTIAL;
            end
            default: w_state_nxt = OCC_EMPTY;
         endcase
      end
   end

   assign o_next        = r_next;
   assign o_count       = r_count;
   assign o_tail        = r_tail;
   assign o_head_nxt_c  = w_head_nxt;
   assign o_count_nxt_c = w_count_nxt;
   assign o_accept_c    = w_accept;

endmodule

// File: rtl/delay_line.sv
// FIFO delay line: each word is held for its own programmed number of cycles
// and released in strict arrival order.
// Ports:
//   clk, reset        clock, async active-low reset
//   valid, in         upstream word offer
//   delay_cfg         delay applied to the word accepted this cycle
//   next              block can accept a word this cycle
//   out, ready        head word and its "delay served" flag (registered)
//   take              downstream consumes the head word
//   flush             synchronous discard of all stored words
//   count             words currently stored
module delay_line
   import delay_line_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   parameter  int unsigned DEPTH  = DEPTH_DEF,
   parameter  int unsigned CNT_W  = CNT_W_DEF,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned OCC_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic [DATA_W-1:0] in,
   input  logic [CNT_W-1:0]  delay_cfg,
   output logic              next,
   output logic [DATA_W-1:0] out,
   output logic              ready,
   input  logic              take,
   input  logic              flush,
   output logic [OCC_W-1:0]  count
);

   // Entry layout at this instance's widths
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  cnt;
   } slot_t;

   slot_t            r_mem [DEPTH];
   slot_t            w_mem_nxt [DEPTH];
   slot_t            w_head_slot;
   logic             r_ready, w_ready_nxt;
   logic [DATA_W-1:0] r_out, w_out_nxt;
   logic [PTR_W-1:0] w_tail, w_head_nxt;
   logic [OCC_W-1:0] w_count_nxt;
   logic             w_accept;

   delay_line_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk           (clk),
      .rst_n         (reset),
      .i_valid       (valid),
      .i_take        (take),
      .i_ready       (r_ready),
      .i_flush       (flush),
      .o_next        (next),
      .o_count       (count),
      .o_tail        (w_tail),
      .o_head_nxt_c  (w_head_nxt),
      .o_count_nxt_c (w_count_nxt),
      .o_accept_c    (w_accept)
   );

   // Storage update and next head presentation
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_mem_nxt[i] = r_mem[i];
         if (r_mem[i].cnt != '0) w_mem_nxt[i].cnt = r_mem[i].cnt - CNT_W'(1);
         if (flush)              w_mem_nxt[i].cnt = '0;
      end
      if (w_accept) begin
         w_mem_nxt[w_tail].data = in;
         w_mem_nxt[w_tail].cnt  = delay_cfg;
      end
      // ready/out are registered, so they are derived from post-edge state
      w_head_slot = w_mem_nxt[w_head_nxt];
      w_ready_nxt = (w_count_nxt != '0) && (w_head_slot.cnt == '0);
      w_out_nxt   = w_ready_nxt ? w_head_slot.data : r_out;
   end

   // Storage array and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_ready <= 1'b0;
         r_out   <= '0;
      end else begin
         r_mem   <= w_mem_nxt;
         r_ready <= w_ready_nxt;
         r_out   <= w_out_nxt;
      end
   end

   assign ready = r_ready;
   assign out   = r_out;

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_delay_line;

   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic       valid;
   logic [7:0] din;
   logic [3:0] dcfg;
   logic       next;
   logic [7:0] out;
   logic       ready;
   logic       take;
   logic       flush;
   logic [2:0] count;

   delay_line dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .in        (din),
      .delay_cfg (dcfg),
      .next      (next),
      .out       (out),
      .ready     (ready),
      .take      (take),
      .flush     (flush),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: each word carries the edge number at which its delay expires
   typedef struct {
      logic [7:0] data;
      int         elig;
   } mword_t;

   mword_t mq[$];
   int     m_edge = 0;
   bit     m_ready = 1'b0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [3:0] dc;
      logic       tk;
      logic       fl;
      int         ec;
      logic       er;
      logic       en;
      logic [7:0] eo;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   function automatic void chk(string nm, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   task automatic model_edge();
      bit tk;
      bit acc;
      m_edge++;
      if (flush) begin
         mq.delete();
      end else begin
         tk  = take && m_ready;
         acc = valid && (mq.size() < DEPTH);
         if (tk) void'(mq.pop_front());
         if (acc) mq.push_back('{data: din, elig: m_edge + int'(dcfg)});
      end
      m_ready = (mq.size() > 0) && (mq[0].elig <= m_edge);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("count", int'(count), mq.size());
      chk("next", int'(next), (mq.size() < DEPTH) ? 1 : 0);
      chk("ready", int'(ready), m_ready ? 1 : 0);
      if (m_ready) chk("out", int'(out), int'(mq[0].data));
   endtask

   task automatic idle_inputs();
      valid = 1'b0;
      din   = 8'h00;
      dcfg  = 4'd0;
      take  = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      int sent;
      int first_cyc;
      int last_cyc;
      bit acc;
      logic [7:0] got[$];

      // single delayed word, then overfill with zero-delay words and drain
      tbl[0]  = '{1'b1, 8'hA5, 4'd3, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h00};
      tbl[1]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h00};
      tbl[2]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'h00};
      tbl[3]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'hA5};
      tbl[4]  = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00};
      tbl[5]  = '{1'b1, 8'h01, 4'd0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h01};
      tbl[6]  = '{1'b1, 8'h02, 4'd0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 8'h01};
      tbl[7]  = '{1'b1, 8'h03, 4'd0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 8'h01};
      tbl[8]  = '{1'b1, 8'h04, 4'd0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 8'h01};
      tbl[9]  = '{1'b1, 8'h05, 4'd0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 8'h01};
      tbl[10] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'h02};
      tbl[11] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 8'h03};
      tbl[12] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h04};
      tbl[13] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00};

      // reset state
      reset = 1'b0;
      idle_inputs();
      #12;
      chk("rst_count", int'(count), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_next", int'(next), 1);
      chk("rst_out", int'(out), 0);
      @(negedge clk);
      reset = 1'b1;

      // vector table
      for (int i = 0; i < NV; i++) begin
         valid = tbl[i].v;
         din   = tbl[i].d;
         dcfg  = tbl[i].dc;
         take  = tbl[i].tk;
         flush = tbl[i].fl;
         step();
         chk("tbl_count", int'(count), tbl[i].ec);
         chk("tbl_ready", int'(ready), int'(tbl[i].er));
         chk("tbl_next", int'(next), int'(tbl[i].en));
         if (tbl[i].er) chk("tbl_out", int'(out), int'(tbl[i].eo));
      end
      idle_inputs();

      // short-delay word stuck behind a long-delay head
      valid = 1'b1; din = 8'h10; dcfg = 4'd6;
      step();
      din = 8'h20; dcfg = 4'd0;
      step();
      idle_inputs();
      waited = 0;
      for (int i = 0; i < 12 && !ready; i++) begin
         step();
         waited++;
      end
      chk("hol_wait", waited, 5);
      chk("hol_out_head", int'(out), 8'h10);
      take = 1'b1;
      step();
      chk("hol_ready_after_take", int'(ready), 1);
      chk("hol_out_second", int'(out), 8'h20);
      step();
      idle_inputs();
      step();

      // continuous stream across pointer wraps
      sent = 0;
      first_cyc = -1;
      last_cyc = -1;
      got.delete();
      for (int cyc = 0; cyc < 60 && got.size() < 12; cyc++) begin
         valid = (sent < 12);
         din   = 8'(sent + 1);
         dcfg  = 4'd2;
         take  = 1'b1;
         if (ready) begin
            got.push_back(out);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         acc = valid && next;
         step();
         if (acc) sent++;
      end
      idle_inputs();
      chk("stream_n", got.size(), 12);
      for (int i = 0; i < got.size(); i++) chk("stream_word", int'(got[i]), i + 1);
      chk("stream_span", last_cyc - first_cyc, 11);
      step();

      // flush together with an offered word
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; din = 8'(8'h31 + i); dcfg = 4'd9;
         step();
      end
      chk("pre_flush_count", int'(count), 3);
      valid = 1'b1; din = 8'h34; dcfg = 4'd0; flush = 1'b1;
      step();
      chk("flush_count", int'(count), 0);
      chk("flush_ready", int'(ready), 0);
      chk("flush_next", int'(next), 1);
      idle_inputs();
      step();
      chk("flush_lost_count", int'(count), 0);
      chk("flush_lost_ready", int'(ready), 0);

      // reset pulsed mid-stream
      valid = 1'b1; din = 8'h41; dcfg = 4'd1;
      step();
      din = 8'h42;
      step();
      idle_inputs();
      chk("prerst_count", int'(count), 2);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_count", int'(count), 0);
      chk("midrst_ready", int'(ready), 0);
      chk("midrst_next", int'(next), 1);
      chk("midrst_out", int'(out), 0);
      mq.delete();
      m_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      valid = 1'b1; din = 8'h55; dcfg = 4'd0;
      step();
      chk("postrst_out", int'(out), 8'h55);
      chk("postrst_count", int'(count), 1);
      idle_inputs();
      take = 1'b1;
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         valid = ($urandom_range(0, 3) != 0);
         din   = 8'($urandom);
         dcfg  = 4'($urandom_range(0, 5));
         take  = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 39) == 0);
         step();
      end
      idle_inputs();
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
